// File: rtl/angle_divider_seq.sv
// Multi-cycle restoring radix-2 unsigned divider for angle range reduction.
// Optional quadrant output is enabled by defining DIVIDER_QUADRANT_EN.
module angle_divider_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_divider,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] divisor_in,
  output logic                  busy,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] remainder_out,
  output logic                  div_by_zero
`ifdef DIVIDER_QUADRANT_EN
  ,
  output logic [1:0]            quadrant
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_reg, state_next;

  // The dividend register doubles as the quotient register: each step shifts
  // one dividend bit out of the top and one quotient bit in at the bottom.
  logic [DATA_WIDTH-1:0] dividend_reg, dividend_next;
  logic [DATA_WIDTH-1:0] divisor_reg, divisor_next;
  logic [DATA_WIDTH:0]   rem_reg, rem_next;
  logic [CNT_W-1:0]      count_reg, count_next;

  logic [DATA_WIDTH-1:0] quot_out_reg, quot_out_next;
  logic [DATA_WIDTH-1:0] rem_out_reg, rem_out_next;
  logic                  dbz_reg, dbz_next;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH+1:0] diff;
  logic                  q_bit;
  logic [DATA_WIDTH:0]   step_rem;
  logic [DATA_WIDTH-1:0] step_quot;

`ifdef DIVIDER_QUADRANT_EN
  logic [1:0] quad_reg, quad_next;
`endif

  // One extra bit on the difference makes its MSB the borrow, i.e. shifted < divisor.
  always_comb begin
    shifted   = {rem_reg[DATA_WIDTH-1:0], dividend_reg[DATA_WIDTH-1]};
    diff      = {rem_reg, dividend_reg[DATA_WIDTH-1]} - {2'b00, divisor_reg};
    q_bit     = ~diff[DATA_WIDTH+1];
    step_rem  = q_bit ? diff[DATA_WIDTH:0] : shifted;
    step_quot = {dividend_reg[DATA_WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_next    = state_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    rem_next      = rem_reg;
    count_next    = count_reg;
    quot_out_next = quot_out_reg;
    rem_out_next  = rem_out_reg;
    dbz_next      = dbz_reg;
`ifdef DIVIDER_QUADRANT_EN
    quad_next     = quad_reg;
`endif

    case (state_reg)
      IDLE, DONE: begin
        if (en_divider) begin
          dividend_next = data_in;
          divisor_next  = divisor_in;
          rem_next      = '0;
          count_next    = CNT_LOAD;
          if (divisor_in != '0) begin
            state_next = RUN;
          end else begin
            state_next    = DONE;
            quot_out_next = '1;
            rem_out_next  = data_in;
            dbz_next      = 1'b1;
`ifdef DIVIDER_QUADRANT_EN
            quad_next     = 2'b11;
`endif
          end
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end

      RUN: begin
        dividend_next = step_quot;
        rem_next      = step_rem;
        if (count_reg == '0) begin
          state_next    = DONE;
          quot_out_next = step_quot;
          rem_out_next  = step_rem[DATA_WIDTH-1:0];
          dbz_next      = 1'b0;
`ifdef DIVIDER_QUADRANT_EN
          quad_next     = step_quot[1:0];
`endif
        end else begin
          count_next = count_reg - 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Result registers clear on reset; working registers are don't-care until the next capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      count_reg    <= '0;
      quot_out_reg <= '0;
      rem_out_reg  <= '0;
      dbz_reg      <= 1'b0;
    end else begin
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      rem_reg      <= rem_next;
      count_reg    <= count_next;
      quot_out_reg <= quot_out_next;
      rem_out_reg  <= rem_out_next;
      dbz_reg      <= dbz_next;
    end
  end

`ifdef DIVIDER_QUADRANT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      quad_reg <= 2'b00;
    end else begin
      quad_reg <= quad_next;
    end
  end

  assign quadrant = quad_reg;
`endif

  assign busy          = (state_reg == RUN);
  assign valid_out     = (state_reg == DONE);
  assign data_out      = quot_out_reg;
  assign remainder_out = rem_out_reg;
  assign div_by_zero   = dbz_reg;

endmodule

// File: tb/tb_angle_divider_seq.sv
// Scoreboard testbench for angle_divider_seq at DATA_WIDTH=32; builds with or
// without DIVIDER_QUADRANT_EN.
module tb_angle_divider_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         en_divider;
  logic [W-1:0] data_in;
  logic [W-1:0] divisor_in;
  logic         busy;
  logic         valid_out;
  logic [W-1:0] data_out;
  logic [W-1:0] remainder_out;
  logic         div_by_zero;
`ifdef DIVIDER_QUADRANT_EN
  logic [1:0]   quadrant;
`endif

  angle_divider_seq #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .en_divider   (en_divider),
    .data_in      (data_in),
    .divisor_in   (divisor_in),
    .busy         (busy),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .remainder_out(remainder_out),
    .div_by_zero  (div_by_zero)
`ifdef DIVIDER_QUADRANT_EN
    ,
    .quadrant     (quadrant)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic [1:0]   quad;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division, all-ones/dividend on zero divisor.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q    = '1;
      e.r    = a;
      e.dbz  = 1'b1;
      e.quad = 2'b11;
    end else begin
      e.q    = a / b;
      e.r    = a % b;
      e.dbz  = 1'b0;
      e.quad = e.q[1:0];
    end
    return e;
  endfunction

  // Output monitor: every valid_out cycle consumes exactly one expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && valid_out) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", {32'd0, data_out}, {32'd0, e.q});
        check("remainder", {32'd0, remainder_out}, {32'd0, e.r});
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
`ifdef DIVIDER_QUADRANT_EN
        check("quadrant", {62'd0, quadrant}, {62'd0, e.quad});
`endif
        if (!e.dbz) begin
          check("invariant", 64'(data_out) * 64'(e.b) + 64'(remainder_out), {32'd0, e.a});
          check("rem_lt_div", {63'd0, (remainder_out < e.b)}, 64'd1);
        end
        $display("op %0d / %0d -> q %0d r %0d dbz %0b", e.a, e.b, data_out, remainder_out,
                 div_by_zero);
      end
    end
  end

  // Drive a start strobe in the current cycle and log its expected result.
  task automatic drive_now(input logic [W-1:0] a, input logic [W-1:0] b);
    en_divider = 1'b1;
    data_in    = a;
    divisor_in = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    en_divider = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive_now(a, b);
  endtask

  // Called in the cycle after the capture edge; lat=1 means valid_out in that cycle.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!valid_out) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int lat;
    issue(a, b);
    wait_valid(lat);
    check(tag, 64'(lat), (b == '0) ? 64'd1 : 64'(W + 1));
    @(negedge clk);
    check("valid_one_cycle", {63'd0, valid_out}, 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    int lat;
    logic [W-1:0] a;
    logic [W-1:0] b;

    reset      = 1'b1;
    en_divider = 1'b0;
    data_in    = '0;
    divisor_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, valid_out}, 64'd0);
    check("rst_data_out", {32'd0, data_out}, 64'd0);
    check("rst_remainder", {32'd0, remainder_out}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
`ifdef DIVIDER_QUADRANT_EN
    check("rst_quadrant", {62'd0, quadrant}, 64'd0);
`endif
    reset = 1'b0;

    run_op(32'd100, 32'd7, "lat_100_7");
    run_op(32'd270, 32'd90, "lat_270_90");
    run_op(32'd450, 32'd90, "lat_450_90");
    run_op(32'd89, 32'd90, "lat_89_90");
    run_op(32'hFFFF_FFFF, 32'd1, "lat_max_1");
    run_op(32'd5, 32'd0, "lat_div_zero");

    // Strobe during RUN is ignored; a strobe in the DONE cycle starts the next op.
    issue(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    en_divider = 1'b1;
    data_in    = 32'd50;
    divisor_in = 32'd5;
    @(negedge clk);
    en_divider = 1'b0;
    check("busy_during_run", {63'd0, busy}, 64'd1);
    wait_valid(lat);
    drive_now(32'd50, 32'd5);
    check("busy_reassert", {63'd0, busy}, 64'd1);
    wait_valid(lat);
    check("lat_back_to_back", 64'(lat), 64'(W + 1));
    @(negedge clk);
    check("valid_one_cycle", {63'd0, valid_out}, 64'd0);

    // Reset mid-operation, with a simultaneous strobe that must not be captured.
    issue(32'd1000, 32'd3);
    repeat (15) @(negedge clk);
    reset      = 1'b1;
    en_divider = 1'b1;
    data_in    = 32'd9;
    divisor_in = 32'd4;
    @(negedge clk);
    sb.delete();
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_valid", {63'd0, valid_out}, 64'd0);
    check("midrst_data_out", {32'd0, data_out}, 64'd0);
    check("midrst_remainder", {32'd0, remainder_out}, 64'd0);
    check("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset      = 1'b0;
    en_divider = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {62'd0, busy, valid_out}, 64'd0);
    repeat (40) @(negedge clk);
    run_op(32'd9, 32'd4, "lat_9_4");

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        3:       b = W'($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      run_op(a, b, "lat_random");
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
